// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit with architectural HI/LO.
// Runs unsigned MULTU (shift-add) and DIVU (restoring division) over WIDTH
// cycles. MULTU and DIVU never stall their own issue. Any later HI/LO-class
// instruction stalls the front of the pipe until the unit returns to IDLE.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic             flush,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] mf_data,
    output logic             mf_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    // opd: multiplicand (MUL) or divisor (DIV)
    // acc: running high product half (MUL) or partial remainder (DIV)
    // shr: multiplier shifting out / low product shifting in (MUL),
    //      dividend shifting out / quotient shifting in (DIV)
    logic [WIDTH-1:0] opd;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shr;

    logic is_multu;
    logic is_divu;
    logic is_mfhi;
    logic is_mflo;
    logic is_mthi;
    logic is_mtlo;
    logic cls;
    logic accept;
    logic last;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_shr;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc;
    logic [WIDTH-1:0] div_shr;

    // Decode funct and form the class / acceptance qualifiers
    always_comb begin
        is_multu = (funct == F_MULTU);
        is_divu  = (funct == F_DIVU);
        is_mfhi  = (funct == F_MFHI);
        is_mflo  = (funct == F_MFLO);
        is_mthi  = (funct == F_MTHI);
        is_mtlo  = (funct == F_MTLO);
        cls      = op_valid && !flush &&
                   (is_multu || is_divu || is_mfhi || is_mflo || is_mthi || is_mtlo);
        last     = (cnt == CNT_W'(WIDTH - 1));
    end

    // One iteration step of each algorithm, evaluated from the current partials
    always_comb begin
        mul_sum   = {1'b0, acc} + (shr[0] ? {1'b0, opd} : '0);
        mul_acc   = mul_sum[WIDTH:1];
        mul_shr   = {mul_sum[0], shr[WIDTH-1:1]};
        div_trial = {acc, shr[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opd};
        div_ge    = (div_trial >= {1'b0, opd});
        // With a zero divisor every step subtracts nothing, so the dividend
        // shifts wholesale into the remainder and the quotient fills with ones.
        div_acc   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_shr   = {shr[WIDTH-2:0], div_ge};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        stall     = cls && busy;
        accept    = cls && !stall;
        mf_valid  = accept && (is_mfhi || is_mflo);
        mf_data   = '0;
        if (mf_valid) begin
            mf_data = is_mfhi ? hi : lo;
        end
        case (state)
            IDLE: begin
                if (accept && is_multu) begin
                    state_nxt = MUL;
                end else if (accept && is_divu) begin
                    state_nxt = DIV;
                end
            end
            MUL, DIV: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result commit and MTHI/MTLO writes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            opd <= '0;
            acc <= '0;
            shr <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_multu) begin
                            opd <= rs_val;
                            shr <= rt_val;
                            acc <= '0;
                            cnt <= '0;
                        end
                        if (is_divu) begin
                            opd <= rt_val;
                            shr <= rs_val;
                            acc <= '0;
                            cnt <= '0;
                        end
                        if (is_mthi) begin
                            hi <= rs_val;
                        end
                        if (is_mtlo) begin
                            lo <= rs_val;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_acc;
                    shr <= mul_shr;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        hi  <= mul_acc;
                        lo  <= mul_shr;
                        cnt <= '0;
                    end
                end
                DIV: begin
                    acc <= div_acc;
                    shr <= div_shr;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        hi  <= div_acc;
                        lo  <= div_shr;
                        cnt <= '0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed bench for ex_muldiv. An arithmetic model of HI/LO
// and the busy window is compared against the DUT on every falling edge;
// directed scenarios add hand-computed literal expectations.
module tb_ex_muldiv;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic          flush;
    logic [5:0]    funct;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic          stall;
    logic          busy;
    logic [W-1:0]  mf_data;
    logic          mf_valid;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    ex_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .flush    (flush),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .stall    (stall),
        .busy     (busy),
        .mf_data  (mf_data),
        .mf_valid (mf_valid),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    int           m_left = 0;

    function automatic logic is_cls(input logic v, input logic f, input logic [5:0] fn);
        return v && !f && (fn == F_MFHI || fn == F_MTHI || fn == F_MFLO ||
                           fn == F_MTLO || fn == F_MULTU || fn == F_DIVU);
    endfunction

    // Model update: results land when the W-cycle busy window has elapsed
    always @(posedge clk) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (is_cls(op_valid, flush, funct)) begin
            case (funct)
                F_MULTU: begin
                    {p_hi, p_lo} <= 64'(rs_val) * 64'(rt_val);
                    m_left <= W;
                end
                F_DIVU: begin
                    if (rt_val == 0) begin
                        p_lo <= '1;
                        p_hi <= rs_val;
                    end else begin
                        p_lo <= rs_val / rt_val;
                        p_hi <= rs_val % rt_val;
                    end
                    m_left <= W;
                end
                F_MTHI:  m_hi <= rs_val;
                F_MTLO:  m_lo <= rs_val;
                default: ;
            endcase
        end
    end

    // Compare process: every falling edge once reset has been applied
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            logic e_busy, e_cls, e_stall, e_mfv;
            logic [W-1:0] e_mfd;
            e_busy  = (m_left > 0);
            e_cls   = is_cls(op_valid, flush, funct);
            e_stall = e_cls && e_busy;
            e_mfv   = e_cls && !e_busy && (funct == F_MFHI || funct == F_MFLO);
            e_mfd   = !e_mfv ? '0 : (funct == F_MFHI ? m_hi : m_lo);
            chk1("m_busy", busy, e_busy);
            chk1("m_stall", stall, e_stall);
            chk1("m_mf_valid", mf_valid, e_mfv);
            chk("m_mf_data", mf_data, e_mfd);
            chk("m_hi", hi, m_hi);
            chk("m_lo", lo, m_lo);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        flush    = 1'b0;
        funct    = f;
        rs_val   = a;
        rt_val   = b;
    endtask

    task automatic idle_in();
        op_valid = 1'b0;
        flush    = 1'b0;
        funct    = F_ADD;
    endtask

    // Present an op and hold it until the unit accepts it
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        drive(f, a, b);
        #1;
        while (stall && n < 40) begin
            step();
            n++;
        end
        chk1("issue_timeout", stall, 1'b0);
        step();
        idle_in();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk1("idle_timeout", busy, 1'b0);
    endtask

    task automatic mf_read(input logic [5:0] f, input logic [W-1:0] exp, input string name);
        drive(f, '0, '0);
        #1;
        chk1({name, "_valid"}, mf_valid, 1'b1);
        chk(name, mf_data, exp);
        step();
        idle_in();
    endtask

    typedef struct {
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{F_DIVU,  32'hFFFFFFFF, 32'h1,       32'h0, 32'hFFFFFFFF};
        vecs[1] = '{F_DIVU,  32'd5,        32'd10,      32'd5, 32'd0};
        vecs[2] = '{F_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0};
        vecs[3] = '{F_MULTU, 32'h1234,     32'h0,       32'h0, 32'h0};
        vecs[4] = '{F_DIVU,  32'h80000000, 32'd3,       32'd2, 32'h2AAAAAAA};
        vecs[5] = '{F_MULTU, 32'h12345678, 32'h10,      32'h1, 32'h23456780};

        rst = 1'b1;
        idle_in();
        rs_val = '0;
        rt_val = '0;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_mf_valid", mf_valid, 1'b0);
        chk("rst_mf_data", mf_data, '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        step();

        // MULTU max*max: busy cycles 1..32, result in cycle 33
        drive(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        chk1("mul_c0_stall", stall, 1'b0);
        chk1("mul_c0_busy", busy, 1'b0);
        step();
        idle_in();
        for (int c = 1; c <= 32; c++) begin
            #1;
            chk1("mul_busy", busy, 1'b1);
            chk1("mul_stall", stall, 1'b0);
            step();
        end
        #1;
        chk1("mul_c33_busy", busy, 1'b0);
        chk("mul_c33_hi", hi, 32'hFFFFFFFE);
        chk("mul_c33_lo", lo, 32'h00000001);
        step();

        // DIVU 100/7 then MFLO from cycle 2: stalls until cycle 33
        drive(F_DIVU, 32'd100, 32'd7);
        #1;
        chk1("div_c0_stall", stall, 1'b0);
        step();
        idle_in();
        step();
        drive(F_MFLO, '0, '0);
        for (int c = 2; c <= 32; c++) begin
            #1;
            chk1("mflo_stall", stall, 1'b1);
            chk1("mflo_wait_valid", mf_valid, 1'b0);
            step();
        end
        #1;
        chk1("mflo_c33_stall", stall, 1'b0);
        chk1("mflo_c33_valid", mf_valid, 1'b1);
        chk("mflo_c33_data", mf_data, 32'd14);
        chk("div_c33_hi", hi, 32'd2);
        step();
        idle_in();

        // DIVU by zero
        drive(F_DIVU, 32'h12345678, 32'h0);
        step();
        idle_in();
        repeat (32) step();
        #1;
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_hi", hi, 32'h12345678);
        step();

        // Reset mid-MULTU, then MTHI in the first cycle after reset
        drive(F_MULTU, 32'd3, 32'd5);
        step();
        idle_in();
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(F_MTHI, 32'h55, '0);
        #1;
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_stall", stall, 1'b0);
        chk("rst_mid_hi", hi, '0);
        chk("rst_mid_lo", lo, '0);
        step();
        idle_in();
        #1;
        chk("mthi_hi", hi, 32'h55);
        chk("mthi_lo", lo, '0);
        step();

        // Flushed MFHI, unflushed MFHI and ADD while busy
        drive(F_MULTU, 32'd7, 32'd9);
        step();
        drive(F_MFHI, '0, '0);
        flush = 1'b1;
        #1;
        chk1("flush_stall", stall, 1'b0);
        chk1("flush_mf_valid", mf_valid, 1'b0);
        flush = 1'b0;
        #1;
        chk1("noflush_stall", stall, 1'b1);
        funct = F_ADD;
        #1;
        chk1("add_stall", stall, 1'b0);
        step();
        idle_in();
        wait_idle();
        mf_read(F_MFLO, 32'd63, "mul79_lo");
        mf_read(F_MFHI, 32'd0, "mul79_hi");

        // MTLO then MFLO
        issue(F_MTLO, 32'h0000A5A5, '0);
        mf_read(F_MFLO, 32'h0000A5A5, "mtlo_rd");

        // Back-to-back: DIVU held behind MULTU serializes
        issue(F_MULTU, 32'd2, 32'd3);
        issue(F_DIVU, 32'd20, 32'd6);
        wait_idle();
        #1;
        chk("b2b_hi", hi, 32'd2);
        chk("b2b_lo", lo, 32'd3);
        step();

        // Directed operand table
        foreach (vecs[i]) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_idle();
            #1;
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
            step();
        end

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
